// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory port arbiter: word width,
// access size encodings, sequencer states and the alignment check.
package mem_pkg;

  localparam int MEM_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE_WR,
    ST_RESP
  } state_t;

  // A data access errors when its size is illegal or its address does not
  // sit on a natural boundary for that size.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] offs);
    isMisaligned = (size == 2'd3) ||
                   ((size == SZ_HALF) && offs[0]) ||
                   ((size == SZ_WORD) && (offs != 2'b00));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// The master side is the core plus the memory array; the slave side is the
// arbiter itself.
interface mem_port_arbiter_if
  import mem_pkg::*;
();

  logic             if_req;
  logic [MEM_W-1:0] if_addr;
  logic             if_gnt;
  logic             if_valid;
  logic [MEM_W-1:0] if_rdata;

  logic             d_req;
  logic             d_we;
  logic [1:0]       d_size;
  logic             d_unsigned;
  logic [MEM_W-1:0] d_addr;
  logic [MEM_W-1:0] d_wdata;
  logic             d_gnt;
  logic             d_valid;
  logic [MEM_W-1:0] d_rdata;
  logic             d_err;

  logic [MEM_W-1:0] mem_adr;
  logic [MEM_W-1:0] mem_wdata;
  logic             mem_we;
  logic [MEM_W-1:0] mem_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_err,
           mem_adr, mem_wdata, mem_we
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_err,
           mem_adr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_port_arbiter_lane.sv
// Combinational byte-lane steering: merges byte/half store data into a read
// word and extracts/extends the addressed lane of a loaded word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [MEM_W-1:0] wordIn,
  input  logic [15:0]      wdata,
  input  logic [1:0]       size,
  input  logic [1:0]       offs,
  input  logic             isUnsigned,
  output logic [MEM_W-1:0] mergedWord,
  output logic [MEM_W-1:0] loadData
);

  logic        [7:0]  byteLane;
  logic        [15:0] halfLane;
  logic signed [7:0]  byteS;
  logic signed [15:0] halfS;

  // Replace only the addressed lane(s); every other lane passes through.
  always_comb begin
    mergedWord = wordIn;
    if (size == SZ_BYTE) begin
      mergedWord[{offs, 3'b000} +: 8] = wdata[7:0];
    end else if (size == SZ_HALF) begin
      mergedWord[{offs[1], 4'b0000} +: 16] = wdata;
    end
  end

  // Pick the addressed lane and widen it, sign-extending unless unsigned.
  always_comb begin
    byteLane = wordIn[{offs, 3'b000} +: 8];
    halfLane = wordIn[{offs[1], 4'b0000} +: 16];
    byteS    = byteLane;
    halfS    = halfLane;
    loadData = wordIn;
    if (size == SZ_BYTE) begin
      loadData = isUnsigned ? MEM_W'(byteLane) : MEM_W'(byteS);
    end else if (size == SZ_HALF) begin
      loadData = isUnsigned ? MEM_W'(halfLane) : MEM_W'(halfS);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter sharing one combinational-read memory port between
// instruction fetch and load/store. One transaction in flight at a time;
// sub-word stores are done as read-modify-write.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] starveCnt;
  logic [1:0]       latOffs;
  logic [15:0]      latWdata;
  logic [1:0]       latSize;
  logic             latWe;
  logic             latUns;
  logic             latSrcD;

  logic             idle;
  logic             starved;
  logic             dWin;
  logic             ifWin;
  logic [MEM_W-1:0] mergedWord;
  logic [MEM_W-1:0] loadData;

  // Arbitration: data normally wins, fetch is forced once it has been starved.
  always_comb begin
    idle    = (state == ST_IDLE);
    starved = (starveCnt == CNT_W'(STARVE_MAX));
    dWin    = idle && bus.d_req && (!starved || !bus.if_req);
    ifWin   = idle && bus.if_req && !dWin;
  end

  assign bus.d_gnt  = dWin;
  assign bus.if_gnt = ifWin;

  mem_lane_align uLane (
    .wordIn    (bus.mem_rdata),
    .wdata     (latWdata),
    .size      (latSize),
    .offs      (latOffs),
    .isUnsigned(latUns),
    .mergedWord(mergedWord),
    .loadData  (loadData)
  );

  // Count data grants taken while fetch is waiting; any fetch grant or a
  // withdrawn fetch request resets the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
    end else if (!bus.if_req || ifWin) begin
      starveCnt <= '0;
    end else if (dWin && !starved) begin
      starveCnt <= starveCnt + CNT_W'(1);
    end
  end

  // Transaction sequencer with registered memory controls and responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      latOffs       <= '0;
      latWdata      <= '0;
      latSize       <= SZ_WORD;
      latWe         <= 1'b0;
      latUns        <= 1'b0;
      latSrcD       <= 1'b0;
      bus.if_valid  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_valid   <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_err     <= 1'b0;
      bus.mem_adr   <= '0;
      bus.mem_wdata <= '0;
      bus.mem_we    <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      bus.d_err    <= 1'b0;
      bus.mem_we   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dWin) begin
            latSrcD     <= 1'b1;
            latOffs     <= bus.d_addr[1:0];
            latSize     <= bus.d_size;
            latWe       <= bus.d_we;
            latUns      <= bus.d_unsigned;
            latWdata    <= bus.d_wdata[15:0];
            bus.mem_adr <= {bus.d_addr[MEM_W-1:2], 2'b00};
            if (isMisaligned(bus.d_size, bus.d_addr[1:0])) begin
              bus.d_valid <= 1'b1;
              bus.d_err   <= 1'b1;
              bus.d_rdata <= '0;
              state       <= ST_RESP;
            end else begin
              if (bus.d_we && (bus.d_size == SZ_WORD)) begin
                bus.mem_we    <= 1'b1;
                bus.mem_wdata <= bus.d_wdata;
              end
              state <= ST_ACCESS;
            end
          end else if (ifWin) begin
            latSrcD     <= 1'b0;
            latOffs     <= bus.if_addr[1:0];
            latSize     <= SZ_WORD;
            latWe       <= 1'b0;
            latUns      <= 1'b0;
            bus.mem_adr <= {bus.if_addr[MEM_W-1:2], 2'b00};
            state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!latSrcD) begin
            bus.if_rdata <= bus.mem_rdata;
            bus.if_valid <= 1'b1;
            state        <= ST_RESP;
          end else if (!latWe) begin
            bus.d_rdata <= loadData;
            bus.d_valid <= 1'b1;
            state       <= ST_RESP;
          end else if (latSize == SZ_WORD) begin
            bus.d_rdata <= '0;
            bus.d_valid <= 1'b1;
            state       <= ST_RESP;
          end else begin
            bus.mem_we    <= 1'b1;
            bus.mem_wdata <= mergedWord;
            state         <= ST_MERGE_WR;
          end
        end
        ST_MERGE_WR: begin
          bus.d_rdata <= '0;
          bus.d_valid <= 1'b1;
          state       <= ST_RESP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
